// File: rtl/seg_display_pkg.sv
// seg_display_pkg
// Shared definitions for the seven-segment display scheduler:
//   - active-low segment codes, ordered {g,f,e,d,c,b,a}
//   - scheduler state type and state constants
//   - seg_decode: BCD nibble to segment code (values above 9 show "0")
//   - max_display_value: largest value that fits in a given number of digits
// Optional feature macro used by the top level: LEADING_ZERO_BLANK_EN
package seg_display_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE    = 2'd0;
   localparam state_t ST_CONVERT = 2'd1;
   localparam state_t ST_DECODE  = 2'd2;

   // Single shared nibble decoder; the scheduler calls it once per cycle.
   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_0;
      endcase
      return seg;
   endfunction

   // 10^num_digits - 1, evaluated at elaboration time.
   function automatic int unsigned max_display_value(input int unsigned num_digits);
      int unsigned v;
      v = 1;
      for (int unsigned i = 0; i < num_digits; i++) begin
         v = v * 10;
      end
      return v - 1;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
// Sequential double-dabble (shift-add-3) binary to BCD converter.
// One bit is consumed per cycle, so a conversion takes exactly BIN_W cycles.
// Ports:
//   clk     - system clock
//   rst     - synchronous active-high reset, abandons any conversion
//   start_i - load bin_i and begin converting (ignored by the engine state)
//   bin_i   - unsigned binary value, sampled only when start_i is high
//   bcd_o   - BCD result, 4*NUM_DIGITS bits, valid from the cycle after done_o
//   done_o  - high during the final conversion cycle
module bin2bcd_seq
   import seg_display_pkg::*;
#(
   parameter int BIN_W      = 14,
   parameter int NUM_DIGITS = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start_i,
   input  logic [BIN_W-1:0]        bin_i,
   output logic [4*NUM_DIGITS-1:0] bcd_o,
   output logic                    done_o
);

   localparam int BCD_W = 4 * NUM_DIGITS;
   localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

   logic [BCD_W-1:0] bcd_q, bcd_d;
   logic [BIN_W-1:0] sh_q, sh_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             active_q, active_d;
   logic [BCD_W-1:0] adj;

   // Every nibble that is 5 or more gets +3 before the shift so that the
   // doubling carries correctly into the next decimal digit.
   always_comb begin
      adj = bcd_q;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
   end

   // Load on start, then shift {BCD, binary} left once per cycle while the
   // down-counter runs; the cycle with cnt==0 is the last shift.
   always_comb begin
      bcd_d    = bcd_q;
      sh_d     = sh_q;
      cnt_d    = cnt_q;
      active_d = active_q;
      if (start_i) begin
         bcd_d    = '0;
         sh_d     = bin_i;
         cnt_d    = CNT_W'(BIN_W - 1);
         active_d = 1'b1;
      end else if (active_q) begin
         {bcd_d, sh_d} = {adj, sh_q} << 1;
         if (cnt_q == '0) begin
            active_d = 1'b0;
         end else begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         bcd_q    <= '0;
         sh_q     <= '0;
         cnt_q    <= '0;
         active_q <= 1'b0;
      end else begin
         bcd_q    <= bcd_d;
         sh_q     <= sh_d;
         cnt_q    <= cnt_d;
         active_q <= active_d;
      end
   end

   assign bcd_o  = bcd_q;
   assign done_o = active_q && (cnt_q == '0);

endmodule

// File: rtl/seg_display_scheduler.sv
// seg_display_scheduler
// Accepts a binary value over valid/ready, converts it to BCD, decodes one
// digit per cycle into shadow registers, then commits all digits to the HEX
// outputs in a single cycle so the display never shows a partial update.
// Out-of-range values skip conversion and display dashes on every digit.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zeros
// (digit 0 always shows its numeral).
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   in_valid     - in_data is valid
//   in_data      - unsigned value to display (BIN_W bits)
//   in_ready     - high only in IDLE
//   hex_out      - active-low segments, digit i at [7*i +: 7]
//   busy         - high while converting or decoding
//   update_done  - one-cycle pulse coinciding with a new hex_out value
//   overflow     - last accepted value did not fit in NUM_DIGITS digits
module seg_display_scheduler
   import seg_display_pkg::*;
#(
   parameter int BIN_W      = 14,
   parameter int NUM_DIGITS = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic [BIN_W-1:0]        in_data,
   output logic                    in_ready,
   output logic [7*NUM_DIGITS-1:0] hex_out,
   output logic                    busy,
   output logic                    update_done,
   output logic                    overflow
);

   localparam int unsigned MAX_VAL = max_display_value(NUM_DIGITS);
   localparam int          IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int          HEX_W   = 7 * NUM_DIGITS;

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic                    dash_q, dash_d;
   logic                    ovf_q, ovf_d;
   logic                    done_q, done_d;
   logic [HEX_W-1:0]        shadow_q, shadow_d;
   logic [HEX_W-1:0]        hex_q, hex_d;
`ifdef LEADING_ZERO_BLANK_EN
   logic                    lz_q, lz_d;
`endif

   logic                    in_range;
   logic                    conv_start;
   logic                    conv_done;
   logic [4*NUM_DIGITS-1:0] bcd;
   logic [3:0]              nib;
   logic [6:0]              seg_cur;

   assign in_range   = 32'(in_data) <= MAX_VAL;
   assign conv_start = (state_q == ST_IDLE) && in_valid && in_range;

   bin2bcd_seq #(
      .BIN_W      (BIN_W),
      .NUM_DIGITS (NUM_DIGITS)
   ) u_bin2bcd (
      .clk     (clk),
      .rst     (rst),
      .start_i (conv_start),
      .bin_i   (in_data),
      .bcd_o   (bcd),
      .done_o  (conv_done)
   );

   // The one shared decoder looks at the digit selected by idx_q. Dash mode
   // overrides the numeral; optional blanking suppresses leading zeros.
   always_comb begin
      nib     = bcd[4*idx_q +: 4];
      seg_cur = seg_decode(nib);
`ifdef LEADING_ZERO_BLANK_EN
      if (lz_q && (nib == 4'd0) && (idx_q != '0)) begin
         seg_cur = SEG_BLANK;
      end
`endif
      if (dash_q) begin
         seg_cur = SEG_DASH;
      end
   end

   // Scheduler next-state: handshake in IDLE, wait for the converter, then
   // walk the digits from most significant down and commit on digit 0.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      dash_d   = dash_q;
      ovf_d    = ovf_q;
      done_d   = 1'b0;
      shadow_d = shadow_q;
      hex_d    = hex_q;
`ifdef LEADING_ZERO_BLANK_EN
      lz_d     = lz_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               idx_d = IDX_W'(NUM_DIGITS - 1);
`ifdef LEADING_ZERO_BLANK_EN
               lz_d  = 1'b1;
`endif
               if (in_range) begin
                  state_d = ST_CONVERT;
                  ovf_d   = 1'b0;
                  dash_d  = 1'b0;
               end else begin
                  state_d = ST_DECODE;
                  ovf_d   = 1'b1;
                  dash_d  = 1'b1;
               end
            end
         end
         ST_CONVERT: begin
            if (conv_done) begin
               state_d = ST_DECODE;
               idx_d   = IDX_W'(NUM_DIGITS - 1);
            end
         end
         ST_DECODE: begin
            shadow_d[7*idx_q +: 7] = seg_cur;
`ifdef LEADING_ZERO_BLANK_EN
            if (nib != 4'd0) begin
               lz_d = 1'b0;
            end
`endif
            if (idx_q == '0) begin
               hex_d   = shadow_d;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               idx_d = idx_q - IDX_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Registers; reset abandons any work and shows "0" on every digit.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         dash_q   <= 1'b0;
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
         shadow_q <= '0;
         hex_q    <= {NUM_DIGITS{SEG_0}};
`ifdef LEADING_ZERO_BLANK_EN
         lz_q     <= 1'b1;
`endif
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         dash_q   <= dash_d;
         ovf_q    <= ovf_d;
         done_q   <= done_d;
         shadow_q <= shadow_d;
         hex_q    <= hex_d;
`ifdef LEADING_ZERO_BLANK_EN
         lz_q     <= lz_d;
`endif
      end
   end

   assign in_ready    = (state_q == ST_IDLE);
   assign busy        = (state_q == ST_CONVERT) || (state_q == ST_DECODE);
   assign update_done = done_q;
   assign overflow    = ovf_q;
   assign hex_out     = hex_q;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// tb_seg_display_scheduler
// Randomised and directed stimulus for seg_display_scheduler. Expected
// displays come from a decimal reference model and are queued at accept
// time; a negedge monitor pops and compares on every update_done.
module tb_seg_display_scheduler;

   localparam int BIN_W      = 14;
   localparam int NUM_DIGITS = 4;
   localparam int HEX_W      = 7 * NUM_DIGITS;
   localparam int MAXV       = 9999;

   typedef struct {
      logic [HEX_W-1:0] hex;
      logic             ovf;
      int               due;
   } exp_t;

   logic             clk;
   logic             rst;
   logic             inValid;
   logic [BIN_W-1:0] inData;
   logic             inReady;
   logic [HEX_W-1:0] hexOut;
   logic             busy;
   logic             updateDone;
   logic             overflow;

   exp_t             sbq[$];
   logic [HEX_W-1:0] committed;
   int               cyc;
   int               busyRun;
   int               errors;
   int               checks;

   logic [6:0] segTbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

   seg_display_scheduler #(
      .BIN_W      (BIN_W),
      .NUM_DIGITS (NUM_DIGITS)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (inValid),
      .in_data     (inData),
      .in_ready    (inReady),
      .hex_out     (hexOut),
      .busy        (busy),
      .update_done (updateDone),
      .overflow    (overflow)
   );

   // Free-running clock and cycle counter (number of rising edges so far).
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Decimal reference: what the display should read for value v.
   function automatic logic [HEX_W-1:0] modelHex(input int v);
      logic [HEX_W-1:0] r;
      int               rem;
      int               d;
      int               p;
      bit               seenNonZero;
      r = '0;
      seenNonZero = 0;
      if (v > MAXV) begin
         for (int i = 0; i < NUM_DIGITS; i++) r[7*i +: 7] = 7'b0111111;
         return r;
      end
      rem = v;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         p = 1;
         for (int j = 0; j < i; j++) p = p * 10;
         d = rem / p;
         rem = rem % p;
         r[7*i +: 7] = segTbl[d];
`ifdef LEADING_ZERO_BLANK_EN
         if (d == 0 && !seenNonZero && i != 0) r[7*i +: 7] = 7'b1111111;
`endif
         if (d != 0) seenNonZero = 1;
      end
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Queue the expected result for an accept that happens on the next edge.
   task automatic pushExpect(input int v, input int k);
      exp_t e;
      e.hex = modelHex(v);
      e.ovf = (v > MAXV);
      e.due = k + (e.ovf ? NUM_DIGITS + 1 : BIN_W + NUM_DIGITS + 1);
      sbq.push_back(e);
   endtask

   // Wait (bounded) until in_ready is seen high, sampled 1 unit after an edge.
   task automatic waitReady(input string name);
      int guard;
      guard = 0;
      while (!inReady && guard < 100) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (!inReady) checkOutput({name, "_ready_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic applyStimulus(input int v);
      @(posedge clk);
      #1;
      inValid = 1'b1;
      inData  = BIN_W'(v);
      waitReady("stim");
      pushExpect(v, cyc);
      @(posedge clk);
      #1;
      inValid = 1'b0;
      inData  = BIN_W'($urandom);
   endtask

   // Hold in_valid across two values; the second must be taken on the
   // update_done cycle of the first.
   task automatic applyPair(input int a, input int b);
      int k1;
      int k2;
      int dueA;
      @(posedge clk);
      #1;
      inValid = 1'b1;
      inData  = BIN_W'(a);
      waitReady("pairA");
      k1 = cyc;
      pushExpect(a, k1);
      dueA = sbq[$].due;
      @(posedge clk);
      #1;
      inData = BIN_W'(b);
      waitReady("pairB");
      k2 = cyc;
      checkOutput("b2b_no_gap", k2, dueA);
      pushExpect(b, k2);
      @(posedge clk);
      #1;
      inValid = 1'b0;
   endtask

   // Start a conversion and reset the block after 'wait' cycles.
   task automatic applyReset(input int v, input int waitCycles);
      @(posedge clk);
      #1;
      inValid = 1'b1;
      inData  = BIN_W'(v);
      waitReady("rst");
      @(posedge clk);
      #1;
      inValid = 1'b0;
      repeat (waitCycles) @(posedge clk);
      #1;
      checkOutput("busy_before_rst", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      sbq.delete();
      committed = {NUM_DIGITS{7'b1000000}};
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("rst_in_ready", {31'd0, inReady}, 32'd1);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_hex", {4'd0, hexOut}, {4'd0, committed});
   endtask

   // Monitor: pops on update_done, otherwise the display must not change.
   always @(negedge clk) begin
      if (rst) begin
         busyRun = 0;
      end else begin
         if (busy) busyRun++;
         if (updateDone) begin
            if (sbq.size() == 0) begin
               checkOutput("unexpected_update", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               checkOutput("hex", {4'd0, hexOut}, {4'd0, e.hex});
               checkOutput("overflow", {31'd0, overflow}, {31'd0, e.ovf});
               checkOutput("latency", cyc, e.due);
               checkOutput("busy_len", busyRun,
                           e.ovf ? NUM_DIGITS : BIN_W + NUM_DIGITS);
               committed = e.hex;
            end
            busyRun = 0;
         end else begin
            checkOutput("hold", {4'd0, hexOut}, {4'd0, committed});
         end
      end
   end

   initial begin
      int r;
      int gap;
      errors    = 0;
      checks    = 0;
      busyRun   = 0;
      rst       = 1'b1;
      inValid   = 1'b0;
      inData    = '0;
      committed = {NUM_DIGITS{7'b1000000}};
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      checkOutput("reset_hex", {4'd0, hexOut}, {4'd0, {NUM_DIGITS{7'b1000000}}});
      checkOutput("reset_ready", {31'd0, inReady}, 32'd1);
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      checkOutput("reset_done", {31'd0, updateDone}, 32'd0);
      checkOutput("reset_ovf", {31'd0, overflow}, 32'd0);

      applyReset(4321, 5);
      repeat (25) @(posedge clk);

      applyStimulus(1234);
      applyStimulus(0);
      applyStimulus(9999);
      applyStimulus(10000);
      applyStimulus(9999);
      applyPair(57, 705);
      applyStimulus(16383);
      applyReset(8888, 16);
      applyStimulus(1);
      applyStimulus(1000);

      for (int n = 0; n < 40; n++) begin
         r = $urandom_range(0, 9);
         if (r == 9) begin
            applyPair($urandom_range(0, 9999), $urandom_range(0, 16383));
         end else if (r < 2) begin
            applyStimulus($urandom_range(10000, 16383));
         end else begin
            applyStimulus($urandom_range(0, 9999));
         end
         gap = $urandom_range(0, 2);
         repeat (gap) @(posedge clk);
      end

      begin
         int guard;
         guard = 0;
         while (sbq.size() != 0 && guard < 200) begin
            @(posedge clk);
            guard++;
         end
         if (sbq.size() != 0) checkOutput("drain_timeout", sbq.size(), 32'd0);
      end
      repeat (5) @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seg_display_scheduler.md
Name: seg_display_scheduler

Overview:
- Sequential controller that takes a binary value over a valid/ready handshake and converts it to BCD with a multi-cycle shift-add-3 engine.
- Time-shares one BCD-to-seven-segment decode function across all digits, one digit per cycle, into shadow registers.
- Commits the shadow registers atomically to the board HEX outputs, so the RNG project's random values appear on the display without tearing.

Parameters:
- BIN_W, 14, width of the binary input value.
- NUM_DIGITS, 4, number of seven-segment digits driven; BCD width is 4*NUM_DIGITS.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  in_data is valid.
- in_data  input  BIN_W  unsigned binary value to display.
- in_ready  output  1  block can accept a value (high only in IDLE).
- hex_out  output  7*NUM_DIGITS  active-low segments {g,f,e,d,c,b,a}; digit i at [7*i +: 7], digit 0 least significant.
- busy  output  1  high in CONVERT or DECODE.
- update_done  output  1  one-cycle pulse when hex_out is updated.
- overflow  output  1  sticky flag: last accepted value exceeded 10^NUM_DIGITS-1.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE; any conversion in progress is abandoned.
  - Every digit of hex_out resets to 7'b1000000 ("0").
  - in_ready=1; busy=0; update_done=0; overflow=0; shadow and BCD registers are cleared.
- Segment codes (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Any nibble above 9 decodes to 1000000. Dash=0111111. Blank=1111111.
- Handshake: a transfer occurs on the clk edge where in_valid && in_ready. in_data is captured in that cycle and never sampled again.
- States: IDLE, CONVERT, DECODE.
- IDLE:
  - in_ready=1.
  - On accept with in_data <= 10^NUM_DIGITS-1: go to CONVERT, clear BCD, load shift register, counter=BIN_W-1, overflow<=0.
  - On accept with an out-of-range value: overflow<=1, skip CONVERT, go to DECODE in dash mode.
- CONVERT (exactly BIN_W cycles):
  - Each cycle, add 3 to every BCD nibble >=5.
  - Then shift {BCD, shift register} left by one.
  - On the cycle with counter==0, go to DECODE with digit index = NUM_DIGITS-1.
- DECODE (exactly NUM_DIGITS cycles):
  - One digit per cycle, from most significant down to index 0.
  - Each cycle writes the shadow digit from the single decode function.
  - Dash mode writes a dash to every digit.
  - At index 0: hex_out <= shadow (including the digit being written that cycle), update_done pulses, go to IDLE.
- Latency: accept at cycle N → hex_out and update_done visible at N+BIN_W+NUM_DIGITS+1. Overflow path: N+NUM_DIGITS+1.
- in_ready is high in the update_done cycle, so back-to-back accepts run with no gap.
- hex_out holds its previous value throughout CONVERT and DECODE; it never shows partial results.
- in_valid outside IDLE is ignored; input is back-pressured.
- Reset asserted mid-CONVERT or mid-DECODE overrides everything, same cycle.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - During DECODE, a register leading_zero is initialised to 1 at the start of DECODE.
  - A digit is blanked (1111111) when its nibble==0 and leading_zero==1; digit 0 is never blanked.
  - leading_zero clears on the first nonzero digit.
  - Dash mode is unaffected.
- Undefined: every digit always shows its numeral, including leading zeros.

Decomposition:
- Package seg_display_pkg holds:
  - the segment-code constants (SEG_0..SEG_9, SEG_DASH, SEG_BLANK);
  - the state enum typedef;
  - the decode function nibble→7 bits;
  - the function computing 10^NUM_DIGITS-1.
- One sub-module, bin2bcd_seq: the double-dabble engine with start/done signals, parameterised by BIN_W and NUM_DIGITS.
- The top block keeps the handshake, the DECODE sequencer and the commit logic.

Test Plan:
- Value 1234 → after 19 cycles, digits 3..0 = 1111001, 0100100, 0110000, 0011001; update_done pulses once; overflow=0.
- Value 0 → all four digits 1000000. With LEADING_ZERO_BLANK_EN: digits 3..1 = 1111111 and digit 0 = 1000000.
- Value 9999 → all digits 0010000. Then value 10000 → all digits 0111111 after 5 cycles; overflow=1.
- in_valid held high with 57 then 705 → second accept on the update_done cycle of the first. Expect hex_out 0000/0057 (blank-mode 57), then 0705: digits 2..0 = 1111000, 1000000, 0010010.
- rst pulsed during CONVERT of 4321 → hex_out stays all 1000000; no update_done; in_ready=1 on the next cycle.
- Stall check → hex_out unchanged throughout busy; busy=1 for exactly BIN_W+NUM_DIGITS cycles per normal accept.
